// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the core load/store path and the UART loader.
// Loader has fixed priority; a saturating stall counter forces a CPU slot after MAX_STALL denials.
module dmem_port_arbiter #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned MEM_LIMIT = 32'h1000,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          boot_mode_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          ldr_valid_i,
  input  logic          ldr_we_i,
  input  logic [AW-1:0] ldr_addr_i,
  input  logic [DW-1:0] ldr_wdata_i,
  output logic          ldr_ready_o,
  output logic [DW-1:0] ldr_rdata_o,
  output logic          ldr_rvalid_o,
  output logic          ldr_err_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int unsigned   CW      = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [AW-1:0] LIMIT   = AW'(MEM_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_LDR  = 2'd2
  } gnt_e;

  gnt_e          gnt;
  logic          force_cpu;
  logic          cpu_in_range;
  logic          ldr_in_range;

  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
  logic          ldr_rvalid_q, ldr_rvalid_d;
  logic          ldr_err_q, ldr_err_d;

  assign cpu_in_range = (cpu_addr_i < LIMIT);
  assign ldr_in_range = (ldr_addr_i < LIMIT);

  // Single-cycle core reads straight through the async memory port.
  assign cpu_rdata_o  = mem_rdata_i;
  assign ldr_rdata_o  = ldr_rdata_q;
  assign ldr_rvalid_o = ldr_rvalid_q;
  assign ldr_err_o    = ldr_err_q;

  // State register: stall counter plus the loader response stage.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      stall_cnt_q  <= '0;
      ldr_rdata_q  <= '0;
      ldr_rvalid_q <= 1'b0;
      ldr_err_q    <= 1'b0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      ldr_rdata_q  <= ldr_rdata_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      ldr_err_q    <= ldr_err_d;
    end
  end

  // Grant decision, port steering and next state.
  always_comb begin
    gnt          = GNT_NONE;
    force_cpu    = 1'b0;
    cpu_stall_o  = 1'b0;
    ldr_ready_o  = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = cpu_addr_i;
    mem_wdata_o  = cpu_wdata_i;
    stall_cnt_d  = '0;
    ldr_rdata_d  = ldr_rdata_q;
    ldr_rvalid_d = 1'b0;
    ldr_err_d    = 1'b0;

    if (reset_i) begin
      if (boot_mode_i) begin
        if (ldr_valid_i) gnt = GNT_LDR;
      end else begin
        force_cpu = cpu_req_i && (stall_cnt_q == CNT_MAX);
        if (ldr_valid_i && !force_cpu) gnt = GNT_LDR;
        else if (cpu_req_i)            gnt = GNT_CPU;
      end

      cpu_stall_o = cpu_req_i && (gnt != GNT_CPU);

      // Counting only outside boot mode keeps the counter at zero across a boot exit.
      if (!boot_mode_i && cpu_stall_o) begin
        stall_cnt_d = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + CW'(1);
      end

      case (gnt)
        GNT_CPU: begin
          mem_we_o = cpu_we_i && cpu_in_range;
        end
        GNT_LDR: begin
          ldr_ready_o = 1'b1;
          mem_addr_o  = ldr_addr_i;
          mem_wdata_o = ldr_wdata_i;
          mem_we_o    = ldr_we_i && ldr_in_range;
          if (!ldr_in_range) begin
            ldr_err_d = 1'b1;
          end else if (!ldr_we_i) begin
            ldr_rvalid_d = 1'b1;
            ldr_rdata_d  = mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
